// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Types and constants shared by the pipeline stage registers.
//   ctrl_t      : packed bundle of every decode control bit/field
//   CTRL_BUBBLE : all-zero control word (a no-op entry)
//   REG_ADDR_W  : register-file address width
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       op1_pc;
        logic       jalr;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : pipeline_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one on this edge (ignored once saturated)
//   count : current value, driven from flops
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// Decode -> execute pipeline register with stall, flush and bubble counting.
//   clk, rst            : clock; asynchronous active-high reset (loads bubble)
//   stall_e             : hold current contents
//   flush_e             : load a bubble (wins over stall_e)
//   valid_d / valid_e   : slot holds a real instruction
//   *_d control bits    : jump, branch, mem_write, alu_src, reg_write,
//                         op1_pc, jalr, result_src[1:0], alu_ctrl[3:0],
//                         funct3[2:0]  -> registered as *_e
//   rd1/rd2/pc/pc_plus4/imm_ext _d : WIDTH-bit data -> registered as *_e
//   rs1/rs2/rd _d       : register addresses -> registered as *_e
//   bubble_count        : saturating count of bubbles inserted since reset
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_e,
    input  logic                  flush_e,

    input  logic                  valid_d,
    input  logic                  jump_d,
    input  logic                  branch_d,
    input  logic                  mem_write_d,
    input  logic                  alu_src_d,
    input  logic                  reg_write_d,
    input  logic                  op1_pc_d,
    input  logic                  jalr_d,
    input  logic [1:0]            result_src_d,
    input  logic [3:0]            alu_ctrl_d,
    input  logic [2:0]            funct3_d,
    input  logic [WIDTH-1:0]      rd1_d,
    input  logic [WIDTH-1:0]      rd2_d,
    input  logic [WIDTH-1:0]      pc_d,
    input  logic [WIDTH-1:0]      pc_plus4_d,
    input  logic [WIDTH-1:0]      imm_ext_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,

    output logic                  valid_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  mem_write_e,
    output logic                  alu_src_e,
    output logic                  reg_write_e,
    output logic                  op1_pc_e,
    output logic                  jalr_e,
    output logic [1:0]            result_src_e,
    output logic [3:0]            alu_ctrl_e,
    output logic [2:0]            funct3_e,
    output logic [WIDTH-1:0]      rd1_e,
    output logic [WIDTH-1:0]      rd2_e,
    output logic [WIDTH-1:0]      pc_e,
    output logic [WIDTH-1:0]      pc_plus4_e,
    output logic [WIDTH-1:0]      imm_ext_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic [CNT_WIDTH-1:0]  bubble_count
);

    ctrl_t                 w_ctrl_d;
    logic                  w_load;
    logic                  w_bubble_inc;

    logic                  r_valid;
    ctrl_t                 r_ctrl;
    logic [WIDTH-1:0]      r_rd1, r_rd2, r_pc, r_pc_plus4, r_imm_ext;
    logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;

    // Pack the decode controls; an invalid slot must never carry side
    // effects, so its write/jump/branch bits are squashed on the way in.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_ctrl_d            = CTRL_BUBBLE;
        w_ctrl_d.jump       = jump_d      & valid_d;
        w_ctrl_d.branch     = branch_d    & valid_d;
        w_ctrl_d.mem_write  = mem_write_d & valid_d;
        w_ctrl_d.reg_write  = reg_write_d & valid_d;
        w_ctrl_d.alu_src    = alu_src_d;
        w_ctrl_d.op1_pc     = op1_pc_d;
        w_ctrl_d.jalr       = jalr_d;
        w_ctrl_d.result_src = result_src_d;
        w_ctrl_d.alu_ctrl   = alu_ctrl_d;
        w_ctrl_d.funct3     = funct3_d;
    end

    assign w_load       = !flush_e && !stall_e;
    // A load of an empty slot is as much a bubble as an explicit flush.
    assign w_bubble_inc = flush_e || (w_load && !valid_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            r_valid    <= 1'b0;
            r_ctrl     <= CTRL_BUBBLE;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_imm_ext  <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (w_load) begin
            r_valid    <= valid_d;
            r_ctrl     <= w_ctrl_d;
            r_rd1      <= rd1_d;
            r_rd2      <= rd2_d;
            r_pc       <= pc_d;
            r_pc_plus4 <= pc_plus4_d;
            r_imm_ext  <= imm_ext_d;
            r_rs1      <= rs1_d;
            r_rs2      <= rs2_d;
            r_rd       <= rd_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble_inc),
        .count (bubble_count)
    );

    assign valid_e      = r_valid;
    assign jump_e       = r_ctrl.jump;
    assign branch_e     = r_ctrl.branch;
    assign mem_write_e  = r_ctrl.mem_write;
    assign alu_src_e    = r_ctrl.alu_src;
    assign reg_write_e  = r_ctrl.reg_write;
    assign op1_pc_e     = r_ctrl.op1_pc;
    assign jalr_e       = r_ctrl.jalr;
    assign result_src_e = r_ctrl.result_src;
    assign alu_ctrl_e   = r_ctrl.alu_ctrl;
    assign funct3_e     = r_ctrl.funct3;
    assign rd1_e        = r_rd1;
    assign rd2_e        = r_rd2;
    assign pc_e         = r_pc;
    assign pc_plus4_e   = r_pc_plus4;
    assign imm_ext_e    = r_imm_ext;
    assign rs1_e        = r_rs1;
    assign rs2_e        = r_rs2;
    assign rd_e         = r_rd;

endmodule : id_ex_reg

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
// Directed bench for id_ex_reg built with CNT_WIDTH=4 so saturation is
// reachable quickly; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_e, flush_e;
    logic             valid_d, jump_d, branch_d, mem_write_d, alu_src_d;
    logic             reg_write_d, op1_pc_d, jalr_d;
    logic [1:0]       result_src_d;
    logic [3:0]       alu_ctrl_d;
    logic [2:0]       funct3_d;
    logic [WIDTH-1:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [4:0]       rs1_d, rs2_d, rd_d;

    logic             valid_e, jump_e, branch_e, mem_write_e, alu_src_e;
    logic             reg_write_e, op1_pc_e, jalr_e;
    logic [1:0]       result_src_e;
    logic [3:0]       alu_ctrl_e;
    logic [2:0]       funct3_e;
    logic [WIDTH-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic [CNT_W-1:0] bubble_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .jump_d(jump_d), .branch_d(branch_d),
        .mem_write_d(mem_write_d), .alu_src_d(alu_src_d),
        .reg_write_d(reg_write_d), .op1_pc_d(op1_pc_d), .jalr_d(jalr_d),
        .result_src_d(result_src_d), .alu_ctrl_d(alu_ctrl_d),
        .funct3_d(funct3_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .imm_ext_d(imm_ext_d), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .rd_d(rd_d),
        .valid_e(valid_e), .jump_e(jump_e), .branch_e(branch_e),
        .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
        .reg_write_e(reg_write_e), .op1_pc_e(op1_pc_e), .jalr_e(jalr_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e),
        .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
        .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e), .rs1_e(rs1_e),
        .rs2_e(rs2_e), .rd_e(rd_e), .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every _d input from one seed-like pattern.
    task automatic drive_all(input logic v, input logic c,
                             input logic [WIDTH-1:0] d, input logic [4:0] a);
        valid_d = v; jump_d = c; branch_d = c; mem_write_d = c;
        alu_src_d = c; reg_write_d = c; op1_pc_d = c; jalr_d = c;
        result_src_d = d[1:0]; alu_ctrl_d = d[3:0]; funct3_d = d[2:0];
        rd1_d = d; rd2_d = ~d; pc_d = d ^ 32'h0000_FFFF;
        pc_plus4_d = d + 32'd4; imm_ext_d = {d[15:0], d[31:16]};
        rs1_d = a; rs2_d = a ^ 5'h1F; rd_d = a + 5'd1;
    endtask

    // Every _e output at bubble value.
    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, valid_e, 0);
        check({tag, ".ctrl"}, {jump_e, branch_e, mem_write_e, alu_src_e,
              reg_write_e, op1_pc_e, jalr_e, result_src_e, alu_ctrl_e,
              funct3_e}, 0);
        check({tag, ".data"}, {rd1_e, rd2_e} | {pc_e, pc_plus4_e} |
              {32'h0, imm_ext_e}, 0);
        check({tag, ".addr"}, {rs1_e, rs2_e, rd_e}, 0);
    endtask

    initial begin
        rst = 1'b1; stall_e = 0; flush_e = 0;
        drive_all(1'b1, 1'b1, 32'h1111_2222, 5'd3);

        // Reset asserted from time zero: bubble outputs without an edge.
        #2;
        check_bubble("reset0");
        check("reset0.cnt", bubble_count, 0);
        tick(); tick();
        rst = 1'b0;

        // Basic load, one-cycle latency.
        drive_all(1'b1, 1'b0, 32'h0, 5'd0);
        reg_write_d = 1; alu_ctrl_d = 4'h2; rd1_d = 32'hDEADBEEF; rd_d = 5'd5;
        jump_d = 1; branch_d = 1; mem_write_d = 1; alu_src_d = 1;
        op1_pc_d = 1; jalr_d = 1; result_src_d = 2'd2; funct3_d = 3'd5;
        rd2_d = 32'h1234_5678; pc_d = 32'h100; pc_plus4_d = 32'h104;
        imm_ext_d = 32'hFFFF_FFF0; rs1_d = 5'd3; rs2_d = 5'd7;
        tick();
        check("load.valid", valid_e, 1);
        check("load.ctrl", {jump_e, branch_e, mem_write_e, alu_src_e,
              reg_write_e, op1_pc_e, jalr_e}, 7'h7F);
        check("load.fields", {result_src_e, alu_ctrl_e, funct3_e}, {2'd2, 4'h2, 3'd5});
        check("load.rd1", rd1_e, 32'hDEADBEEF);
        check("load.rd2", rd2_e, 32'h1234_5678);
        check("load.pc", {pc_e, pc_plus4_e}, {32'h100, 32'h104});
        check("load.imm", imm_ext_e, 32'hFFFF_FFF0);
        check("load.addr", {rs1_e, rs2_e, rd_e}, {5'd3, 5'd7, 5'd5});
        check("load.cnt", bubble_count, 0);

        // Stall three cycles with changing inputs (including valid_d=0).
        stall_e = 1;
        for (int i = 0; i < 3; i++) begin
            drive_all(i[0], ~i[0], 32'hA000_0000 + i, 5'(i + 10));
            tick();
            check("stall.rd1", rd1_e, 32'hDEADBEEF);
            check("stall.ctrl", {valid_e, reg_write_e, alu_ctrl_e, rd_e},
                  {1'b1, 1'b1, 4'h2, 5'd5});
            check("stall.pc", pc_plus4_e, 32'h104);
            check("stall.cnt", bubble_count, 0);
        end

        // Flush beats stall.
        flush_e = 1; stall_e = 1;
        drive_all(1'b1, 1'b1, 32'h5555_AAAA, 5'd9);
        tick();
        check_bubble("flush");
        check("flush.cnt", bubble_count, 1);

        // Invalid load: side-effect bits squashed, rest passes, counts.
        flush_e = 0; stall_e = 0;
        drive_all(1'b0, 1'b1, 32'h0000_A5A7, 5'd8);
        tick();
        check("inv.valid", valid_e, 0);
        check("inv.sq", {reg_write_e, mem_write_e, jump_e, branch_e}, 0);
        check("inv.pass", {alu_src_e, op1_pc_e, jalr_e, alu_ctrl_e}, {3'b111, 4'h7});
        check("inv.data", {rd1_e, rd_e}, {32'h0000_A5A7, 5'd9});
        check("inv.cnt", bubble_count, 2);

        // rd=0 with reg_write passes through untouched.
        drive_all(1'b1, 1'b1, 32'h0000_0010, 5'd0);
        rd_d = 5'd0;
        tick();
        check("x0.rw", {valid_e, reg_write_e, rd_e}, {1'b1, 1'b1, 5'd0});
        check("x0.cnt", bubble_count, 2);

        // Async reset mid-stall, released between edges.
        stall_e = 1;
        rst = 1;
        #2;
        check_bubble("areset");
        check("areset.cnt", bubble_count, 0);
        #1 rst = 0;
        tick();  // still stalled: bubble held, no count
        check("postrst.stall", {valid_e, rd1_e}, 0);
        check("postrst.cnt", bubble_count, 0);
        stall_e = 0;
        drive_all(1'b1, 1'b0, 32'h0BAD_F00D, 5'd4);
        tick();
        check("postrst.load", {valid_e, rd1_e, rd_e}, {1'b1, 32'h0BAD_F00D, 5'd5});
        check("postrst.cnt2", bubble_count, 0);

        // Saturation at 4'hF across 20 flushes.
        flush_e = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat.cnt", bubble_count, (i > 15) ? 15 : i);
        end
        // Invalid load at saturation must not wrap either.
        flush_e = 0; valid_d = 0;
        tick();
        check("sat.hold", bubble_count, 4'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_id_ex_reg
